cpu_sdr_bridge: RTL and testbench

CPU_SDR_BRIDGE -- requirements
Module: cpu_sdr_bridge

---
 rtl/cpu_sdr_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_cpu_sdr_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sdr_bridge.sv
// CPU bus to SDRAM toggle-handshake bridge with a one-entry read-hit buffer,
// bounded SDRAM wait and a sticky timeout flag.
module cpu_sdr_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic        CLK_32M,
    input  logic        reset_n,
    input  logic        mem_sel,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [23:0] mem_addr,
    input  logic        mem_writable,
    input  logic [1:0]  mem_be,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    output logic        sdr_req,
    input  logic        sdr_ack,
    output logic [23:0] sdr_addr,
    output logic        sdr_we,
    output logic [1:0]  sdr_be,
    output logic [15:0] sdr_wdata,
    input  logic [15:0] sdr_rdata,
    output logic        timeout_err
);

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W:0]    TO_LIM  = (CNT_W + 1)'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [DATA_W-1:0] RD_ERR  = 16'hFFFF;

    typedef enum logic [2:0] {IDLE, LOOKUP, ISSUE, WAIT, DONE, HOLD} state_t;

    state_t              state_q, state_d;
    logic                start_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                abort_q, abort_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0]   buf_tag_q, buf_tag_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic [DATA_W-1:0]   mem_rdata_d;
    logic                mem_ready_d;
    logic                sdr_req_d;
    logic [ADDR_W-1:0]   sdr_addr_d;
    logic                sdr_we_d;
    logic [BE_W-1:0]     sdr_be_d;
    logic [DATA_W-1:0]   sdr_wdata_d;
    logic                timeout_err_d;

    logic start, ack_match, hit, abort_now, timed_out;

    always_comb begin
        start     = mem_sel & (mem_rd | mem_wr);
        ack_match = (sdr_ack == sdr_req);
        hit       = CACHE_EN && buf_valid_q && (buf_tag_q == addr_q);
        abort_now = abort_q | ~mem_sel;
        timed_out = ({1'b0, cnt_q} + (CNT_W + 1)'(1)) >= TO_LIM;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        abort_d       = abort_q;
        cnt_d         = cnt_q;
        buf_valid_d   = buf_valid_q;
        buf_tag_d     = buf_tag_q;
        buf_data_d    = buf_data_q;
        mem_rdata_d   = mem_rdata;
        mem_ready_d   = 1'b0;
        sdr_req_d     = sdr_req;
        sdr_addr_d    = sdr_addr;
        sdr_we_d      = sdr_we;
        sdr_be_d      = sdr_be;
        sdr_wdata_d   = sdr_wdata;
        timeout_err_d = timeout_err;

        case (state_q)
            IDLE: begin
                if (start && !start_q) begin
                    addr_d  = mem_addr;
                    be_d    = mem_be;
                    wdata_d = mem_wdata;
                    we_d    = mem_wr;
                    abort_d = 1'b0;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (we_q && !mem_writable) begin
                    mem_ready_d = 1'b1;
                    state_d     = DONE;
                end else if (!we_q && hit) begin
                    mem_rdata_d = buf_data_q;
                    mem_ready_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                sdr_req_d   = ~sdr_req;
                sdr_addr_d  = addr_q;
                sdr_we_d    = we_q;
                sdr_be_d    = be_q;
                sdr_wdata_d = wdata_q;
                cnt_d       = '0;
                abort_d     = abort_now;
                state_d     = WAIT;
            end
            WAIT: begin
                abort_d = abort_now;
                if (ack_match) begin
                    mem_ready_d = ~abort_now;
                    if (!sdr_we) begin
                        mem_rdata_d = sdr_rdata;
                        buf_data_d  = sdr_rdata;
                        buf_tag_d   = sdr_addr;
                        buf_valid_d = 1'b1;
                    end else if (buf_tag_q == sdr_addr) begin
                        // keep the buffer coherent with accepted writes
                        if (sdr_be[0]) buf_data_d[7:0]  = sdr_wdata[7:0];
                        if (sdr_be[1]) buf_data_d[15:8] = sdr_wdata[15:8];
                    end
                    state_d = DONE;
                end else if (timed_out) begin
                    mem_ready_d   = ~abort_now;
                    mem_rdata_d   = RD_ERR;
                    timeout_err_d = 1'b1;
                    state_d       = HOLD;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (ack_match) begin
                    buf_valid_d = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // start_q resets high so a strobe held through reset is not seen as an edge
    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            start_q     <= 1'b1;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            abort_q     <= 1'b0;
            cnt_q       <= '0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            mem_rdata   <= '0;
            mem_ready   <= 1'b0;
            sdr_req     <= 1'b0;
            sdr_addr    <= '0;
            sdr_we      <= 1'b0;
            sdr_be      <= '0;
            sdr_wdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            abort_q     <= abort_d;
            cnt_q       <= cnt_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            mem_rdata   <= mem_rdata_d;
            mem_ready   <= mem_ready_d;
            sdr_req     <= sdr_req_d;
            sdr_addr    <= sdr_addr_d;
            sdr_we      <= sdr_we_d;
            sdr_be      <= sdr_be_d;
            sdr_wdata   <= sdr_wdata_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_cpu_sdr_bridge.sv
// Bench for cpu_sdr_bridge: directed scenarios plus random CPU traffic against
// a word-level memory model and an SDRAM responder with programmable ack delay.
module tb_cpu_sdr_bridge;

    logic        clk;
    logic        rst_n;
    logic        mem_sel, mem_rd, mem_wr, mem_writable;
    logic [23:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        sdr_req, sdr_ack, sdr_we;
    logic [23:0] sdr_addr;
    logic [1:0]  sdr_be;
    logic [15:0] sdr_wdata, sdr_rdata;
    logic        timeout_err;

    cpu_sdr_bridge dut (
        .CLK_32M      (clk),
        .reset_n      (rst_n),
        .mem_sel      (mem_sel),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_writable (mem_writable),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .sdr_req      (sdr_req),
        .sdr_ack      (sdr_ack),
        .sdr_addr     (sdr_addr),
        .sdr_we       (sdr_we),
        .sdr_be       (sdr_be),
        .sdr_wdata    (sdr_wdata),
        .sdr_rdata    (sdr_rdata),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // SDRAM contents as seen by the responder, and the CPU-visible reference
    logic [15:0] sdram   [logic [23:0]];
    logic [15:0] ref_mem [logic [23:0]];
    logic [23:0] pool [4] = '{24'h000100, 24'h000101, 24'h002000, 24'hFFFFFF};

    int   ack_delay = 3;
    bit   ack_hold  = 1'b0;
    int   toggles   = 0;
    int   wait_cnt  = 0;
    logic req_prev  = 1'b0;

    bit          buf_valid = 1'b0;
    logic [23:0] buf_tag   = '0;
    logic [15:0] last_rd   = '0;

    function automatic logic [15:0] dflt(input logic [23:0] a);
        return a[15:0] ^ 16'h3C96;
    endfunction

    function automatic logic [15:0] sd_get(input logic [23:0] a);
        if (sdram.exists(a)) return sdram[a];
        return dflt(a);
    endfunction

    function automatic logic [15:0] ref_get(input logic [23:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SDRAM controller model: acks ack_delay cycles after each request toggle
    initial begin
        logic [15:0] m;
        sdr_ack   = 1'b0;
        sdr_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sdr_ack  = 1'b0;
                wait_cnt = 0;
                req_prev = 1'b0;
            end else begin
                if (sdr_req !== req_prev) begin
                    toggles++;
                    req_prev = sdr_req;
                end
                if (sdr_req !== sdr_ack && !ack_hold) begin
                    wait_cnt++;
                    if (wait_cnt >= ack_delay) begin
                        if (sdr_we) begin
                            m = sd_get(sdr_addr);
                            if (sdr_be[0]) m[7:0]  = sdr_wdata[7:0];
                            if (sdr_be[1]) m[15:8] = sdr_wdata[15:8];
                            sdram[sdr_addr] = m;
                        end else begin
                            sdr_rdata = sd_get(sdr_addr);
                        end
                        sdr_ack  = sdr_req;
                        wait_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic cpu_access(input bit wr, input logic [23:0] a, input logic [1:0] be,
                              input logic [15:0] wd, input bit writable,
                              output int lat, output logic [15:0] rd, output int extra);
        @(negedge clk);
        mem_addr     = a;
        mem_be       = be;
        mem_wdata    = wd;
        mem_writable = writable;
        mem_wr       = wr;
        mem_rd       = ~wr;
        mem_sel      = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!mem_ready && lat < 400);
        rd    = mem_rdata;
        extra = 0;
        @(negedge clk);
        mem_sel = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (mem_ready) extra++;
        end
    endtask

    // One CPU access checked against the reference rules
    task automatic do_op(input string tag, input bit wr, input logic [23:0] a,
                         input logic [1:0] be, input logic [15:0] wd,
                         input bit writable, input int delay);
        int lat, extra, t0, exp_lat, exp_tog;
        logic [15:0] rd, exp_rd, m;
        ack_delay = delay;
        t0 = toggles;
        if ((wr && !writable) || (!wr && buf_valid && buf_tag == a)) begin
            exp_lat = 2;
            exp_tog = 0;
        end else begin
            exp_lat = 3 + delay;
            exp_tog = 1;
        end
        exp_rd = wr ? last_rd : ref_get(a);
        cpu_access(wr, a, be, wd, writable, lat, rd, extra);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_tog"}, 32'(toggles - t0), 32'(exp_tog));
        chk({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
        chk({tag, "_extra"}, 32'(extra), 32'd0);
        if (wr && writable) begin
            m = ref_get(a);
            if (be[0]) m[7:0]  = wd[7:0];
            if (be[1]) m[15:8] = wd[15:8];
            ref_mem[a] = m;
        end
        if (!wr) begin
            buf_valid = 1'b1;
            buf_tag   = a;
            last_rd   = exp_rd;
        end
    endtask

    initial begin
        int lat, extra, t0, seen;
        logic [15:0] rd;

        rst_n = 1'b0;
        mem_sel = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; mem_writable = 1'b0;
        mem_addr = '0; mem_be = '0; mem_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(mem_ready), 32'd0);
        chk("rst_req", 32'(sdr_req), 32'd0);
        chk("rst_rdata", 32'(mem_rdata), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);

        // strobe already active when reset releases
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (mem_ready) seen++; end
        chk("held_ready", 32'(seen), 32'd0);
        chk("held_tog", 32'(toggles), 32'd0);
        @(negedge clk);
        mem_sel = 1'b0; mem_rd = 1'b0;
        @(negedge clk);

        sdram[24'h000100]   = 16'hA55A;
        ref_mem[24'h000100] = 16'hA55A;
        do_op("miss", 1'b0, 24'h000100, 2'b11, 16'h0000, 1'b1, 5);
        do_op("hit", 1'b0, 24'h000100, 2'b11, 16'h0000, 1'b1, 5);
        do_op("wr_merge", 1'b1, 24'h000100, 2'b01, 16'h1234, 1'b1, 3);
        do_op("hit_merged", 1'b0, 24'h000100, 2'b11, 16'h0000, 1'b1, 3);
        chk("merged_value", 32'(last_rd), 32'h0000A534);
        do_op("wr_ro", 1'b1, 24'h000100, 2'b11, 16'hBEEF, 1'b0, 3);
        do_op("hit_after_ro", 1'b0, 24'h000100, 2'b11, 16'h0000, 1'b1, 3);

        // ack withheld: timeout, then a late ack drains HOLD
        ack_hold = 1'b1;
        t0 = toggles;
        cpu_access(1'b0, 24'h003000, 2'b11, 16'h0000, 1'b1, lat, rd, extra);
        chk("to_lat", 32'(lat), 32'd258);
        chk("to_rdata", 32'(rd), 32'h0000FFFF);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_extra", 32'(extra), 32'd0);
        ack_delay = 2;
        ack_hold  = 1'b0;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (mem_ready) seen++; end
        chk("hold_ready", 32'(seen), 32'd0);
        chk("to_tog", 32'(toggles - t0), 32'd1);
        buf_valid = 1'b0;
        last_rd   = 16'hFFFF;
        do_op("after_hold", 1'b0, 24'h000100, 2'b11, 16'h0000, 1'b1, 4);

        // mem_sel drops while the SDRAM access is outstanding
        ack_delay = 8;
        t0 = toggles;
        @(negedge clk);
        mem_addr = 24'h002222; mem_sel = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0;
        repeat (4) @(negedge clk);
        mem_sel = 1'b0; mem_rd = 1'b0;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (mem_ready) seen++; end
        chk("abort_ready", 32'(seen), 32'd0);
        chk("abort_tog", 32'(toggles - t0), 32'd1);
        buf_valid = 1'b0;
        do_op("after_abort", 1'b0, 24'h000100, 2'b11, 16'h0000, 1'b1, 2);

        for (int i = 0; i < 40; i++) begin
            do_op("rnd", ($urandom_range(9) < 4), pool[$urandom_range(3)],
                  2'($urandom), 16'($urandom), ($urandom_range(3) != 0),
                  int'($urandom_range(8, 1)));
        end

        // timeout_err is still set from above; reset in WAIT must clear it
        do_op("pre_rst", 1'b0, 24'h002000, 2'b11, 16'h0000, 1'b1, 1);
        ack_hold = 1'b1;
        @(negedge clk);
        mem_addr = 24'h004444; mem_sel = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(mem_ready), 32'd0);
        chk("arst_req", 32'(sdr_req), 32'd0);
        chk("arst_rdata", 32'(mem_rdata), 32'd0);
        chk("arst_err", 32'(timeout_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t0 = toggles;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (mem_ready) seen++; end
        chk("arst_held_ready", 32'(seen), 32'd0);
        chk("arst_held_tog", 32'(toggles - t0), 32'd0);
        @(negedge clk);
        mem_sel = 1'b0; mem_rd = 1'b0;
        ack_hold  = 1'b0;
        buf_valid = 1'b0;
        last_rd   = 16'h0000;
        do_op("after_rst", 1'b0, 24'h002000, 2'b11, 16'h0000, 1'b1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
